// File: rtl/float_to_fixed.sv
// float_to_fixed: multi-cycle conversion of an IEEE half-precision operand
// into a two's-complement 8.8 fixed-point value, one shift bit per cycle.
// The value is sig x 2^(exp-17) in 8.8 units with sig = {1, mant}.
// Optional build macro FLOAT_TO_FIXED_ROUND_NEAREST_EN: when defined, the
// right-shift path rounds to nearest-even; when undefined it truncates.
// Both builds have identical latency.
module float_to_fixed #(
    parameter int MAX_RSH = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] float_in,
    output logic [15:0] fixed_out,
    output logic        ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FIN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [4:0] MAX_RSH_C = 5'(MAX_RSH);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] float_r;
    logic [15:0] mag_r;
    logic [4:0]  cnt_r;
    logic        sign_r;
    logic        sat_r;
    logic        dir_left_r;
    logic [15:0] fixed_out_r;
    logic        ack_r;
    logic        busy_r;
    logic        ack_nxt_s;
    logic        busy_nxt_s;
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
    logic        guard_r;
    logic        sticky_r;
`endif

    // decode of the captured operand, used only in LOAD
    logic [4:0]  exp_s;
    logic        is_zero_s;
    logic        is_sat_s;
    logic        is_left_s;
    logic [4:0]  rsh_s;
    logic [4:0]  n_load_s;
    logic [15:0] mag_fin_s;
    logic [15:0] result_s;

    assign exp_s     = float_r[14:10];
    assign is_zero_s = (exp_s == 5'd0);
    assign is_sat_s  = (exp_s >= 5'd22);
    assign is_left_s = (exp_s >= 5'd17);
    assign rsh_s     = 5'd17 - exp_s;

    // shift count: left by exp-17, or right by 17-exp clamped to MAX_RSH
    always_comb begin
        n_load_s = 5'd0;
        if (is_left_s) begin
            n_load_s = exp_s - 5'd17;
        end else if (rsh_s > MAX_RSH_C) begin
            n_load_s = MAX_RSH_C;
        end else begin
            n_load_s = rsh_s;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LOAD: begin
                if (is_zero_s || is_sat_s) begin
                    state_nxt_s = ST_FIN;
                end else if (n_load_s != 5'd0) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_FIN;
                end
            end
            ST_SHIFT: begin
                if (cnt_r <= 5'd1) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_FIN:  state_nxt_s = ST_DONE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // status outputs derived from the state being entered, so they register cleanly
    always_comb begin
        ack_nxt_s  = 1'b0;
        busy_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_LOAD, ST_SHIFT, ST_FIN: busy_nxt_s = 1'b1;
            ST_DONE:                   ack_nxt_s  = 1'b1;
            default: begin
                ack_nxt_s  = 1'b0;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // final magnitude (optionally rounded), sign application and saturation
    always_comb begin
        mag_fin_s = mag_r;
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
        if (guard_r && (sticky_r || mag_r[0])) begin
            mag_fin_s = mag_r + 16'd1;
        end else begin
            mag_fin_s = mag_r;
        end
`endif
        if (sat_r) begin
            result_s = sign_r ? 16'h8000 : 16'h7FFF;
        end else if (sign_r) begin
            result_s = 16'd0 - mag_fin_s;
        end else begin
            result_s = mag_fin_s;
        end
    end

    // datapath: capture, load decode, serial shift, result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            float_r     <= 16'h0000;
            mag_r       <= 16'h0000;
            cnt_r       <= 5'd0;
            sign_r      <= 1'b0;
            sat_r       <= 1'b0;
            dir_left_r  <= 1'b0;
            fixed_out_r <= 16'h0000;
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
            guard_r     <= 1'b0;
            sticky_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        float_r <= float_in;
                    end
                end
                ST_LOAD: begin
                    // zero ignores sign; special paths carry no shift
                    sign_r     <= float_r[15] & ~is_zero_s;
                    sat_r      <= is_sat_s;
                    dir_left_r <= is_left_s;
                    if (is_zero_s || is_sat_s) begin
                        mag_r <= 16'h0000;
                        cnt_r <= 5'd0;
                    end else begin
                        mag_r <= {5'b00000, 1'b1, float_r[9:0]};
                        cnt_r <= n_load_s;
                    end
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
                    guard_r  <= 1'b0;
                    sticky_r <= 1'b0;
`endif
                end
                ST_SHIFT: begin
                    cnt_r <= cnt_r - 5'd1;
                    if (dir_left_r) begin
                        mag_r <= {mag_r[14:0], 1'b0};
                    end else begin
                        mag_r <= {1'b0, mag_r[15:1]};
`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
                        guard_r  <= mag_r[0];
                        sticky_r <= sticky_r | guard_r;
`endif
                    end
                end
                ST_FIN: begin
                    fixed_out_r <= result_s;
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

    // registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            ack_r  <= ack_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

    assign fixed_out = fixed_out_r;
    assign ack       = ack_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed self-checking bench for float_to_fixed (default MAX_RSH = 12).
module tb_float_to_fixed;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] float_in;
    logic [15:0] fixed_out;
    logic        ack;
    logic        busy;

    int n_checks;
    int n_fail;

    float_to_fixed #(.MAX_RSH(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .float_in  (float_in),
        .fixed_out (fixed_out),
        .ack       (ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // one conversion: start sampled at edge k, ack expected after edge k+lat
    task automatic run_conv(input string tag, input logic [15:0] f,
                            input logic [15:0] expv, input int lat);
        int cyc;
        cyc = 0;
        @(negedge clk);
        float_in = f;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        float_in = 16'hFFFF;
        if (lat > 1) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        end
        check({tag, "_ack_clr"}, {31'd0, ack}, 32'd0);
        while (ack !== 1'b1 && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(lat));
        check({tag, "_val"}, {16'd0, fixed_out}, {16'd0, expv});
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic [15:0] exp_round;
        logic [15:0] exp_h43ff;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        float_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fixed", {16'd0, fixed_out}, 32'h0000);
        check("rst_ack",   {31'd0, ack},       32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        @(negedge clk);
        reset = 1'b1;

`ifdef FLOAT_TO_FIXED_ROUND_NEAREST_EN
        exp_round = 16'h0001;
        exp_h43ff = 16'h0400;
`else
        exp_round = 16'h0000;
        exp_h43ff = 16'h03FF;
`endif

        run_conv("one",      16'h3C00, 16'h0100, 4);
        run_conv("neg6",     16'hC600, 16'hFA00, 2);
        run_conv("p2m8",     16'h1C00, 16'h0001, 12);
        run_conv("zero",     16'h0000, 16'h0000, 2);
        run_conv("negzero",  16'h8000, 16'h0000, 2);
        run_conv("satpos",   16'h7BFF, 16'h7FFF, 2);
        run_conv("satneg",   16'hD800, 16'h8000, 2);
        run_conv("neginf",   16'hFC00, 16'h8000, 2);
        run_conv("round",    16'h1A00, exp_round, 13);
        // 1.5 * 2^-4 = 24/256
        run_conv("h2e00",    16'h2E00, 16'h0018, 8);
        // 1.5 * 2^-6 = 6/256
        run_conv("h2600",    16'h2600, 16'h0006, 10);
        run_conv("maxleft",  16'h57FF, 16'h7FF0, 6);
        run_conv("negleft",  16'hD7FF, 16'h8010, 6);
        run_conv("clamp",    16'h0400, 16'h0000, 14);
        run_conv("h43ff",    16'h43FF, exp_h43ff, 3);

        // start held for three edges: only one conversion, ack stays up in DONE
        @(negedge clk);
        float_in = 16'h3C00;
        start    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (ack !== 1'b1 && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("hold_ack", {31'd0, ack}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("hold_ack_stay", {31'd0, ack}, 32'd1);
        check("hold_busy",     {31'd0, busy}, 32'd0);
        check("hold_val",      {16'd0, fixed_out}, 32'h0100);

        // abandon a conversion during SHIFT; last result 0x0100 must clear
        @(negedge clk);
        float_in = 16'h1C00;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_ack",   {31'd0, ack},       32'd0);
        check("midrst_fixed", {16'd0, fixed_out}, 32'h0000);
        check("midrst_busy",  {31'd0, busy},      32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("postrst_noack", {31'd0, ack}, 32'd0);
        run_conv("postrst", 16'h3C00, 16'h0100, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
